updown_count_lim: RTL
=====================

Name: updown_count_lim

Overview:
- Parametrised successor to the 8-bit up/down counter with load and clear.
- Generalised width; adds count enable, a programmable upper limit (modulo-N), wrap or saturate end behaviour, a terminal-count pulse and sticky overflow/underflow flags.
- Used as a general event, timer or address counter. Sits directly behind control logic that drives mode/ld/en.

Parameters:
- WIDTH, 8, counter width in bits (legal range 2..32).
- RST_VAL, 0, value of count after async reset. Must be <= 2**WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- clr_n  input  1  asynchronous active-low reset. Single clock domain; reset is asynchronous and active-low.
- sclr  input  1  synchronous clear, active-high.
- ld  input  1  synchronous load of d_in.
- d_in  input  WIDTH  load value.
- en  input  1  count enable.
- mode  input  1  direction: 1 = up, 0 = down.
- sat  input  1  end behaviour: 1 = saturate, 0 = wrap.
- max_val  input  WIDTH  inclusive upper limit of the count range [0, max_val].
- count  output  WIDTH  registered count value.
- tc  output  1  registered terminal-count pulse.
- ovf  output  1  sticky flag: an up-count wrapped.
- unf  output  1  sticky flag: a down-count wrapped.
- at_max  output  1  combinational, count == max_val.
- at_zero  output  1  combinational, count == 0.

Behaviour:
- Async reset (clr_n=0), effective immediately and independent of clk:
  - count=RST_VAL, tc=0, ovf=0, unf=0.
  - Reset mid-count aborts the count; counting resumes on the first posedge after clr_n rises.
- Priority per posedge: sclr > ld > en > hold.
- sclr=1: count=0, ovf=0, unf=0, tc=0.
- ld=1: count = min(d_in, max_val); tc=0; flags unchanged.
- en=1, count > max_val (max_val lowered below count): count = max_val; tc=0; flags unchanged. Takes priority over the direction rules below.
- en=1, mode=1 (up):
  - count < max_val: count+1, tc=0.
  - count == max_val, sat=0: count=0, tc=1, ovf=1.
  - count == max_val, sat=1: hold, tc=1, ovf unchanged.
- en=1, mode=0 (down):
  - count > 0: count-1, tc=0.
  - count == 0, sat=0: count=max_val, tc=1, unf=1.
  - count == 0, sat=1: hold, tc=1, unf unchanged.
- en=0 with no sclr/ld: count holds, tc=0.
- tc is high for exactly the cycle following each boundary event. It stays high every cycle while a saturated count keeps attempting past the bound.
- Latency: one clock from control input to count/tc. at_max/at_zero follow count with no added delay.
- Arithmetic is WIDTH-bit unsigned; no intermediate overflow is possible, because boundaries are checked before ±1.
- max_val=0: range is {0}. Every enabled cycle is a boundary event (tc=1; wrap sets ovf or unf by direction).
- mode, sat and max_val are sampled each posedge. A change takes effect on the next edge with no pipeline flush.

Decomposition:
- Shared package updown_pkg:
  - constants DIR_DOWN=1'b0, DIR_UP=1'b1, END_WRAP=1'b0, END_SAT=1'b1.
  - a next-state select encoding (HOLD, CLR, LOAD, INC, DEC, WRAP_LO, WRAP_HI, CLAMP) used by the datapath mux.
- One natural sub-module: updown_next_sel. Combinational next-state/flag decode (priority, boundary compare, tc/ovf/unf set terms). The top level keeps the registers and the output compares.

Test Plan:
- Async reset: WIDTH=8, RST_VAL=0. Counting at count=37, pulse clr_n low between edges -> count=0, tc=0, ovf=0, unf=0 immediately; counting from 0 resumes on the first edge after release.
- Up wrap: max_val=5, sat=0, mode=1, en=1 from 0 -> count 1,2,3,4,5,0; tc=1 only in the cycle count=0; ovf=1 and stays 1 until sclr.
- Down wrap: max_val=5, sat=0, mode=0 from count=1 -> 0, then 5 with tc=1 and unf=1; ovf unaffected.
- Saturate: max_val=200, sat=1, ld d_in=198, then up -> 199, 200, 200, 200; tc=1 on each held cycle; ovf stays 0; at_max=1 at 200.
- Load clamp and priority: max_val=200, ld=1, d_in=250 -> count=200. Same cycle sclr=1, ld=1 -> count=0. ld=1 with en=1 -> load wins.
- Limit lowered: count=150, max_val changed to 100, en=1 mode=1 -> count=100, tc=0; next edge -> 0 with tc=1, ovf=1.

Source files
------------

// File: rtl/updown_count_lim_pkg.sv
// updown_pkg: direction/end-behaviour constants and the datapath next-state select encoding.
package updown_pkg;
   localparam logic DIR_DOWN = 1'b0;
   localparam logic DIR_UP   = 1'b1;
   localparam logic END_WRAP = 1'b0;
   localparam logic END_SAT  = 1'b1;
   typedef enum logic [2:0] {
      HOLD, CLR, LOAD, INC, DEC, WRAP_LO, WRAP_HI, CLAMP
   } sel_e;
endpackage

// File: rtl/updown_count_lim_if.sv
// updown_count_lim_if: control inputs and count/status outputs of the limited up/down counter.
interface updown_count_lim_if #(parameter int WIDTH = 8);
   logic             sclr, ld, en, mode, sat;
   logic [WIDTH-1:0] d_in, max_val, count;
   logic             tc, ovf, unf, at_max, at_zero;
   modport master (output sclr, ld, d_in, en, mode, sat, max_val,
                   input  count, tc, ovf, unf, at_max, at_zero);
   modport slave  (input  sclr, ld, d_in, en, mode, sat, max_val,
                   output count, tc, ovf, unf, at_max, at_zero);
endinterface

// File: rtl/updown_count_lim_next_sel.sv
// updown_next_sel: priority and boundary decode selecting the next count source and flag set terms.
module updown_next_sel import updown_pkg::*; #(parameter int WIDTH = 8) (
   input  logic             sclr,
   input  logic             ld,
   input  logic             en,
   input  logic             mode,
   input  logic             sat,
   input  logic [WIDTH-1:0] count,
   input  logic [WIDTH-1:0] max_val,
   output sel_e             sel,
   output logic             tc_nxt,
   output logic             ovf_set,
   output logic             unf_set
);
   logic at_top, at_bot, above;
   assign at_top = count == max_val;
   assign at_bot = count == '0;
   assign above  = count > max_val;
   always_comb begin
      sel     = HOLD;
      tc_nxt  = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (sclr) sel = CLR;
      else if (ld) sel = LOAD;
      else if (en) begin
         // a lowered limit pulls the count back into range before any direction rule applies
         if (above) sel = CLAMP;
         else if (mode == DIR_UP) begin
            if (!at_top) sel = INC;
            else begin
               tc_nxt  = 1'b1;
               sel     = (sat == END_SAT) ? HOLD : WRAP_LO;
               ovf_set = sat == END_WRAP;
            end
         end else begin
            if (!at_bot) sel = DEC;
            else begin
               tc_nxt  = 1'b1;
               sel     = (sat == END_SAT) ? HOLD : WRAP_HI;
               unf_set = sat == END_WRAP;
            end
         end
      end
   end
endmodule

// File: rtl/updown_count_lim.sv
// updown_count_lim: parametrised up/down counter with load, clear, modulo limit, wrap/saturate and sticky flags.
module updown_count_lim import updown_pkg::*; #(
   parameter int WIDTH   = 8,
   parameter int RST_VAL = 0
) (
   input logic              clk,
   input logic              clr_n,
   updown_count_lim_if.slave bus
);
   logic [WIDTH-1:0] count, count_nxt, ld_val;
   logic             tc, ovf, unf, tc_nxt, ovf_set, unf_set;
   sel_e             sel;
   assign ld_val = (bus.d_in > bus.max_val) ? bus.max_val : bus.d_in;
   updown_next_sel #(.WIDTH(WIDTH)) u_sel (
      .sclr(bus.sclr), .ld(bus.ld), .en(bus.en), .mode(bus.mode), .sat(bus.sat),
      .count(count), .max_val(bus.max_val), .sel(sel),
      .tc_nxt(tc_nxt), .ovf_set(ovf_set), .unf_set(unf_set)
   );
   always_comb begin
      count_nxt = count;
      case (sel)
         CLR, WRAP_LO:   count_nxt = '0;
         LOAD:           count_nxt = ld_val;
         INC:            count_nxt = count + WIDTH'(1);
         DEC:            count_nxt = count - WIDTH'(1);
         WRAP_HI, CLAMP: count_nxt = bus.max_val;
         default:        count_nxt = count;
      endcase
   end
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         count <= WIDTH'(RST_VAL);
         tc    <= 1'b0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         count <= count_nxt;
         tc    <= tc_nxt;
         ovf   <= !bus.sclr && (ovf || ovf_set);
         unf   <= !bus.sclr && (unf || unf_set);
      end
   end
   assign bus.count   = count;
   assign bus.tc      = tc;
   assign bus.ovf     = ovf;
   assign bus.unf     = unf;
   assign bus.at_max  = count == bus.max_val;
   assign bus.at_zero = count == '0;
endmodule
